// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a wrap-around address range of a registered-output
// ROM and delivers the words on a valid/ready stream. A 2-entry output FIFO
// plus a one-bit in-flight flag absorb the ROM's one-cycle read latency, so a
// read is only issued when its word is guaranteed a FIFO slot.
module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued;
  logic              inflight;
  logic              done_q;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;

  logic push;
  logic pop;
  logic accept;
  logic finish;

  // The word returning from the ROM this cycle is pushed; a handshake pops.
  assign push     = inflight;
  assign pop      = m_valid && m_ready;
  assign m_valid  = (occ != 2'd0);
  assign m_data   = fifo_mem[rd_ptr];
  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign rom_addr = addr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and read issue; a read is allowed only if, counting the
  // word in flight and this cycle's pop, the FIFO still has room for it.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_next = state;
    rom_en     = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (len != '0) state_next = RUN;
        end
      end
      RUN: begin
        rom_en = (issued < len_q) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        if ((issued + {{ADDR_W{1'b0}}, rom_en}) == len_q) state_next = DRAIN;
      end
      DRAIN: begin
        // Finish on the final handshake so done/!busy appear the cycle after.
        if (!inflight && (occ == {1'b0, pop})) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transfer bookkeeping: address walk, issue count, in-flight flag, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      len_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr   <= base_addr;
        len_q  <= len;
        issued <= '0;
      end else if (rom_en) begin
        addr   <= addr + ADDR_W'(1);
        issued <= issued + (ADDR_W + 1)'(1);
      end
      inflight <= rom_en;
      done_q   <= (accept && (len == '0)) || finish;
    end
  end

  // Output FIFO: two entries, pointer-indexed, occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two storage words are reset as well, because m_data reads
      // the head entry directly and must be 0 out of reset.
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rom_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader: a registered ROM model (ROM[a] = a ^ 5)
// and a transaction-level reference that predicts, per cycle, the issue
// decision, stream validity and completion from counts of issued and
// delivered words, and the data order from the address range.
module tb_rom_stream_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;

  rom_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Registered-output ROM model.
  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= rom_addr ^ 4'h5;
  end

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transfer. mode 0: ready high; 1: ready low in cycles 4..9;
  // 2: random ready. inject: cycle of an extra start (base 9) while busy.
  task automatic run_xfer(input int b, input int n, input int mode, input int inject);
    int  q[$];
    int  iss_cyc[$];
    int  issued;
    int  hs;
    int  last_hs;
    int  arrived;
    int  outstanding;
    bit  exp_valid;
    bit  exp_pop;
    bit  exp_en;
    bit  exp_done;
    bit  exp_busy;
    bit  finished;
    for (int i = 0; i < n; i++) q.push_back(((b + i) % DEPTH) ^ 5);
    issued   = 0;
    hs       = 0;
    last_hs  = -10;
    finished = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(posedge clk);
      #1;
      start     = (cyc == 0) || (cyc == inject);
      base_addr = (cyc == 0) ? ADDR_W'(b) : ADDR_W'(9);
      len       = (cyc == 0) ? (ADDR_W + 1)'(n) : (ADDR_W + 1)'(5);
      case (mode)
        1:       m_ready = !(cyc >= 4 && cyc <= 9);
        2:       m_ready = ($urandom_range(0, 2) != 0);
        default: m_ready = 1'b1;
      endcase
      @(negedge clk);
      // A word is in the FIFO two cycles after its read was issued.
      arrived = 0;
      foreach (iss_cyc[k]) if (iss_cyc[k] <= cyc - 2) arrived++;
      outstanding = issued - hs;
      exp_valid = (arrived - hs) > 0;
      exp_pop   = exp_valid && m_ready;
      exp_en    = (n > 0) && (cyc >= 1) && (issued < n) &&
                  ((outstanding - int'(exp_pop)) < 2);
      exp_done  = (n == 0) ? (cyc == 1) : (hs == n && cyc == last_hs + 1);
      exp_busy  = (n > 0) && (cyc >= 1) && !exp_done;
      check("rom_en", int'(rom_en), int'(exp_en));
      check("m_valid", int'(m_valid), int'(exp_valid));
      check("busy", int'(busy), int'(exp_busy));
      check("done", int'(done), int'(exp_done));
      check("outstanding", int'(outstanding <= 2), 1);
      if (exp_en) begin
        check("rom_addr", int'(rom_addr), (b + issued) % DEPTH);
        iss_cyc.push_back(cyc);
        issued++;
      end
      if (exp_valid && !m_ready) check("hold_data", int'(m_data), q[0]);
      if (exp_pop) begin
        check("m_data", int'(m_data), q.pop_front());
        hs++;
        last_hs = cyc;
      end
      if (exp_done) begin
        finished = 1'b1;
        check("word_count", hs, n);
      end
    end
    start = 1'b0;
    if (!finished) check("timeout", 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rom_en"}, int'(rom_en), 0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_m_data"}, int'(m_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int rb;
    int rn;
    int rinj;
    // Power-on reset.
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic, wrap, backpressure, edge lengths, start while busy.
    run_xfer(3, 4, 0, -1);
    run_xfer(14, 4, 0, -1);
    run_xfer(0, 16, 1, -1);
    run_xfer(0, 16, 2, -1);
    run_xfer(7, 0, 0, -1);
    run_xfer(5, 16, 0, -1);
    run_xfer(4, 6, 0, 3);

    // Randomized transfers with random backpressure.
    for (int t = 0; t < 12; t++) begin
      rb   = int'($urandom_range(0, DEPTH - 1));
      rn   = int'($urandom_range(0, DEPTH));
      rinj = (rn > 0) ? int'($urandom_range(1, 3)) : -1;
      run_xfer(rb, rn, 2, rinj);
    end

    // Reset mid-transfer: word 0 on the stream, word 1 in flight.
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 4'd0; len = 5'd16; m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_valid", int'(m_valid), 1);
    rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    run_xfer(2, 1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
